// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings and default sizing.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int DEF_TIMEOUT = 15;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear and reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/flush/bubble sequencer with a memory-wait FSM, timeout trap and
// saturating stall/flush performance counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_timeout_q;
    logic       mem_stall;
    logic       hazard_stall;

    assign mem_stall = mem_req & ~mem_ready;

    // Output priority: ERROR > memory stall > branch > hazard.
    always_comb begin
        freeze_if     = 1'b0;
        freeze_id     = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        freeze_all    = 1'b0;
        hazard_stall  = 1'b0;
        if (!rst) begin
            if (state_q == ST_ERROR || mem_stall) begin
                freeze_all = 1'b1;
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
            end else if (branch_taken) begin
                flush_if_id   = 1'b1;
                bubble_id_exe = 1'b1;
            end else if (hazard) begin
                freeze_if     = 1'b1;
                freeze_id     = 1'b1;
                bubble_id_exe = 1'b1;
                hazard_stall  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == TIMEOUT_C) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_q        <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_q | (state_d == ST_ERROR);
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .srst    (rst),
        .inc_i   (freeze_all | hazard_stall),
        .clr_i   (1'b0),
        .count_o (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .srst    (rst),
        .inc_i   (flush_if_id),
        .clr_i   (1'b0),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: a default-sized instance and a small one (TIMEOUT=3, CNT_W=3) share stimulus.
module tb_pipeline_stall_controller;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst, hazard, branch_taken, mem_req, mem_ready;

    logic        a_fi, a_fid, a_bub, a_fl, a_fa, a_to;
    logic [15:0] a_sc, a_fc;
    logic        b_fi, b_fid, b_bub, b_fl, b_fa, b_to;
    logic [2:0]  b_sc, b_fc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller dut_a (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(a_fi), .freeze_id(a_fid), .bubble_id_exe(a_bub),
        .flush_if_id(a_fl), .freeze_all(a_fa), .mem_timeout(a_to),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    pipeline_stall_controller #(.TIMEOUT(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(b_fi), .freeze_id(b_fid), .bubble_id_exe(b_bub),
        .flush_if_id(b_fl), .freeze_all(b_fa), .mem_timeout(b_to),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-22s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Control vector order: {freeze_if, freeze_id, bubble_id_exe, flush_if_id, freeze_all}
    function automatic logic [31:0] ctl_a();
        return {27'd0, a_fi, a_fid, a_bub, a_fl, a_fa};
    endfunction

    function automatic logic [31:0] ctl_b();
        return {27'd0, b_fi, b_fid, b_bub, b_fl, b_fa};
    endfunction

    initial begin
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        tick();
        hazard = 1'b1;
        mem_req = 1'b1;
        #1;
        chk("rst_ctl_forced_0", ctl_a(), 32'h00);
        tick();
        hazard = 1'b0; mem_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(dut_a.state_q), 32'(ST_RUN));
        chk("rst_stall_cnt", a_sc, 0);
        chk("rst_flush_cnt", a_fc, 0);
        chk("rst_timeout", a_to, 0);

        // Hazard alone for two cycles
        hazard = 1'b1; #1;
        chk("haz_c0_ctl", ctl_a(), 32'b11100);
        tick();
        chk("haz_c1_ctl", ctl_a(), 32'b11100);
        tick();
        hazard = 1'b0; #1;
        chk("haz_idle_ctl", ctl_a(), 32'h00);
        chk("haz_stall_cnt", a_sc, 2);
        chk("haz_flush_cnt", a_fc, 0);

        // Branch overrides hazard
        do_reset();
        hazard = 1'b1; branch_taken = 1'b1; #1;
        chk("br_ctl", ctl_a(), 32'b00110);
        tick();
        hazard = 1'b0; branch_taken = 1'b0; #1;
        chk("br_flush_cnt", a_fc, 1);
        chk("br_stall_cnt", a_sc, 0);

        // Same-cycle mem_req/mem_ready in RUN is free
        mem_req = 1'b1; mem_ready = 1'b1; #1;
        chk("memrdy_ctl", ctl_a(), 32'h00);
        tick();
        chk("memrdy_state", 32'(dut_a.state_q), 32'(ST_RUN));
        mem_req = 1'b0; mem_ready = 1'b0;

        // Four-cycle memory wait with a branch pulse inside it
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 1);
            #1;
            chk($sformatf("memw_c%0d_ctl", i), ctl_a(), 32'b11001);
            tick();
        end
        branch_taken = 1'b0;
        chk("memw_state", 32'(dut_a.state_q), 32'(ST_MEM_WAIT));
        mem_ready = 1'b1; #1;
        chk("memw_ready_ctl", ctl_a(), 32'h00);
        tick();
        mem_req = 1'b0; mem_ready = 1'b0; #1;
        chk("memw_back_run", 32'(dut_a.state_q), 32'(ST_RUN));
        chk("memw_stall_cnt", a_sc, 4);
        chk("memw_flush_cnt", a_fc, 0);

        // Timeout on the small instance (TIMEOUT=3)
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("to_pre_state", 32'(dut_b.state_q), 32'(ST_MEM_WAIT));
        chk("to_pre_flag", b_to, 0);
        tick();
        chk("to_state", 32'(dut_b.state_q), 32'(ST_ERROR));
        chk("to_flag", b_to, 1);
        mem_req = 1'b0; #1;
        chk("to_err_ctl", ctl_b(), 32'b11001);
        tick();
        chk("to_flag_hold", b_to, 1);
        chk("to_err_ctl_hold", ctl_b(), 32'b11001);

        // Reset in the middle of a wait
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rmw_stall_cnt", a_sc, 5);
        rst = 1'b1; #1;
        chk("rmw_rst_ctl", ctl_a(), 32'h00);
        tick();
        rst = 1'b0; mem_req = 1'b0; #1;
        chk("rmw_state", 32'(dut_a.state_q), 32'(ST_RUN));
        chk("rmw_stall_clr", a_sc, 0);
        chk("rmw_flush_clr", a_fc, 0);
        chk("rmw_b_timeout_clr", b_to, 0);
        chk("rmw_b_state", 32'(dut_b.state_q), 32'(ST_RUN));

        // Saturation on the 3-bit counter
        hazard = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("sat_reach7", b_sc, 7);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_hold7", b_sc, 7);
        chk("sat_wide_10", a_sc, 10);
        hazard = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central pipeline-control sequencer for the 5-stage ARM core.
- Takes three inputs: the hazard flag from the hazard detection unit, branch_taken from EXE, and the memory-stage request/ready handshake with the SRAM controller.
- Produces every freeze, flush and bubble control for the pipeline registers.
- Owns a memory-wait FSM with timeout, plus saturating performance counters for stall and flush cycles.

Parameters:
- TIMEOUT, 15, consecutive MEM_WAIT cycles without mem_ready before entering ERROR (range 1..255).
- CNT_W, 16, width of the stall_count and flush_count counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard  input  1  data-hazard stall request from the hazard detection unit.
- branch_taken  input  1  EXE stage resolved a taken branch this cycle.
- mem_req  input  1  MEM stage holds a load/store this cycle.
- mem_ready  input  1  SRAM controller completes the access this cycle.
- freeze_if  output  1  hold the PC and the IF stage.
- freeze_id  output  1  hold the IF/ID register.
- bubble_id_exe  output  1  load a NOP into the ID/EXE register.
- flush_if_id  output  1  clear the IF/ID register.
- freeze_all  output  1  hold all pipeline registers (memory wait).
- mem_timeout  output  1  sticky error flag, set on entering ERROR.
- stall_count  output  CNT_W  saturating count of stall cycles.
- flush_count  output  CNT_W  saturating count of branch-flush cycles.

Behaviour:
- Reset: sampled on the clk edge, rst=1 has priority over everything.
  - state <= RUN, wait counter <= 0, stall_count/flush_count <= 0, mem_timeout <= 0.
  - While rst=1, all combinational control outputs are forced to 0.
  - A reset asserted mid-wait or in ERROR returns the block to RUN on the next edge.
- FSM states: RUN, MEM_WAIT, ERROR (2-bit encoding).
- Transitions:
  - RUN -> MEM_WAIT when mem_req=1 and mem_ready=0. The wait counter loads 1.
  - MEM_WAIT -> RUN when mem_ready=1. The wait counter clears.
  - MEM_WAIT stays while mem_ready=0. The wait counter increments.
  - MEM_WAIT -> ERROR when mem_ready=0 and the counter equals TIMEOUT.
  - ERROR is terminal until rst.
- Outputs are combinational from state and the current inputs (zero latency). Priority, highest first:
  1. ERROR: freeze_all=1, freeze_if=1, freeze_id=1; the other controls are 0.
  2. Memory stall (mem_req=1 and mem_ready=0, any non-ERROR state): freeze_all=1, freeze_if=1, freeze_id=1; bubble_id_exe=0, flush_if_id=0.
     - branch_taken and hazard are ignored because EXE and ID are frozen and will re-present their requests.
  3. Branch (branch_taken=1): flush_if_id=1, bubble_id_exe=1, all freezes 0.
     - The branch overrides hazard because the stalled ID instruction is squashed.
  4. Hazard (hazard=1): freeze_if=1, freeze_id=1, bubble_id_exe=1.
  5. Otherwise all controls are 0.
- In MEM_WAIT with mem_ready=1, freeze_all drops in that same cycle; the MEM stage advances on that edge.
- mem_req with mem_ready=1 in the same cycle in RUN causes no stall and no state change.
- mem_timeout is registered: it rises on the edge that enters ERROR and holds at 1 until rst.
- stall_count increments on each edge where freeze_all=1 or the hazard stall (item 4) is active.
- flush_count increments on each edge where flush_if_id=1.
- Both counters saturate at 2^CNT_W-1 with no wrap. Neither counts during rst.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2;
  - the default TIMEOUT and CNT_W values.
- One natural sub-module, sat_counter: parameterised width, inc and clr inputs, synchronous active-high reset, saturates at all-ones. It is instantiated twice, once for stall_count and once for flush_count.
- The FSM, wait counter and priority decode stay in the top module.

Test Plan:
- Hazard alone: hazard=1 for 2 cycles, no mem_req/branch -> freeze_if=freeze_id=bubble_id_exe=1 both cycles; stall_count=2; flush_count=0.
- Branch beats hazard: hazard=1 and branch_taken=1 together for 1 cycle -> flush_if_id=1, bubble_id_exe=1, freeze_if=0; flush_count=1, stall_count=0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then mem_ready=1:
  - freeze_all=1 for exactly 4 cycles and 0 in the ready cycle;
  - state returns to RUN;
  - stall_count=4;
  - a branch_taken pulse during the wait produces no flush.
- Timeout: TIMEOUT=3, mem_req=1, mem_ready never asserted -> ERROR entered after 3 wait cycles; mem_timeout=1 and freeze_all stays 1 even after mem_req drops.
- Reset mid-wait: rst=1 for one cycle during MEM_WAIT with stall_count=5 -> all controls 0 during reset; next cycle state=RUN, counters=0, mem_timeout=0.
- Saturation: CNT_W=3, hazard held 10 cycles -> stall_count reaches 7 and holds at 7.
